// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, op codes, FSM encoding and latch layouts for
// the MEM stage. Latches travel between stages as flat vectors; the packed
// structs below define their field order (first field = MSB).
package mem_stage_pkg;

    localparam int DBITS     = 32;
    localparam int REGNOBITS = 5;
    localparam int BE_BITS   = DBITS / 8;
    localparam int OPBITS    = 6;

    typedef logic [OPBITS-1:0] op_t;

    localparam op_t OP_LB  = 6'd1;
    localparam op_t OP_LH  = 6'd2;
    localparam op_t OP_LW  = 6'd3;
    localparam op_t OP_LBU = 6'd4;
    localparam op_t OP_LHU = 6'd5;
    localparam op_t OP_SB  = 6'd6;
    localparam op_t OP_SH  = 6'd7;
    localparam op_t OP_SW  = 6'd8;
    localparam op_t OP_ADD = 6'd9;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                 valid;
        logic [DBITS-1:0]     inst;
        logic [DBITS-1:0]     PC;
        op_t                  op_I;
        logic [DBITS-1:0]     inst_count;
        logic [DBITS-1:0]     result;
        logic [DBITS-1:0]     st_data;
        logic [REGNOBITS-1:0] rd;
        logic                 wr_reg;
        logic [DBITS-1:0]     bus_canary;
    } agex_latch_t;

    typedef struct packed {
        logic                 valid;
        logic [DBITS-1:0]     inst;
        logic [DBITS-1:0]     PC;
        op_t                  op_I;
        logic [DBITS-1:0]     inst_count;
        logic [DBITS-1:0]     wb_data;
        logic [REGNOBITS-1:0] rd;
        logic                 wr_reg;
        logic                 misalign;
        logic [DBITS-1:0]     bus_canary;
    } mem_latch_t;

    localparam int AGEX_LATCH_WIDTH       = $bits(agex_latch_t);
    localparam int MEM_LATCH_WIDTH        = $bits(mem_latch_t);
    localparam int FROM_MEM_TO_AGEX_WIDTH = 1;
    // {mem_stall, fwd_valid, fwd_rd, fwd_data}
    localparam int FROM_MEM_TO_DE_WIDTH   = 2 + REGNOBITS + DBITS;

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane logic for the MEM stage.
//   op       - op_I of the instruction in MEM
//   addr_lo  - low two bits of the effective address
//   st_data  - raw store data
//   rdata    - raw load word from memory
//   is_mem   - op is a load or store
//   is_ld    - op is a load
//   misalign - halfword not on a 2-byte boundary, or word not on 4
//   be/wdata - byte enables and lane-replicated store data
//   ld_data  - extracted, sign/zero-extended load result
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [OPBITS-1:0]  op,
    input  logic [1:0]         addr_lo,
    input  logic [DBITS-1:0]   st_data,
    input  logic [DBITS-1:0]   rdata,
    output logic               is_mem,
    output logic               is_ld,
    output logic               misalign,
    output logic [BE_BITS-1:0] be,
    output logic [DBITS-1:0]   wdata,
    output logic [DBITS-1:0]   ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        is_mem   = 1'b0;
        is_ld    = 1'b0;
        misalign = 1'b0;
        be       = 4'b1111;
        wdata    = st_data;
        ld_data  = rdata;
        case (op)
            OP_LB: begin
                is_mem  = 1'b1;
                is_ld   = 1'b1;
                ld_data = {{24{byte_sel[7]}}, byte_sel};
            end
            OP_LBU: begin
                is_mem  = 1'b1;
                is_ld   = 1'b1;
                ld_data = {24'd0, byte_sel};
            end
            OP_LH: begin
                is_mem   = 1'b1;
                is_ld    = 1'b1;
                misalign = addr_lo[0];
                ld_data  = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                is_mem   = 1'b1;
                is_ld    = 1'b1;
                misalign = addr_lo[0];
                ld_data  = {16'd0, half_sel};
            end
            OP_LW: begin
                is_mem   = 1'b1;
                is_ld    = 1'b1;
                misalign = (addr_lo != 2'd0);
            end
            OP_SB: begin
                is_mem = 1'b1;
                be     = 4'b0001 << addr_lo;
                wdata  = {4{st_data[7:0]}};
            end
            OP_SH: begin
                is_mem   = 1'b1;
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{st_data[15:0]}};
            end
            OP_SW: begin
                is_mem   = 1'b1;
                misalign = (addr_lo != 2'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Takes the AGEX latch, runs loads/stores
// against a valid/ready data-memory port with variable response latency,
// stalls upstream while an access is outstanding and publishes the MEM latch
// plus forwarding info.
//   clk, reset           - clock, synchronous active-low reset
//   from_AGEX_latch      - incoming instruction (agex_latch_t)
//   MEM_latch_out        - registered result for WB (mem_latch_t)
//   from_MEM_to_AGEX     - {mem_stall}
//   from_MEM_to_DE       - {mem_stall, fwd_valid, fwd_rd, fwd_data}
//   dmem_req_*           - request channel (held stable until ready)
//   dmem_rsp_*           - load response channel
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [AGEX_LATCH_WIDTH-1:0]       from_AGEX_latch,
    output logic [MEM_LATCH_WIDTH-1:0]        MEM_latch_out,
    output logic [FROM_MEM_TO_AGEX_WIDTH-1:0] from_MEM_to_AGEX,
    output logic [FROM_MEM_TO_DE_WIDTH-1:0]   from_MEM_to_DE,
    output logic                              dmem_req_valid,
    input  logic                              dmem_req_ready,
    output logic                              dmem_req_we,
    output logic [DBITS-1:0]                  dmem_req_addr,
    output logic [DBITS-1:0]                  dmem_req_wdata,
    output logic [BE_BITS-1:0]                dmem_req_be,
    input  logic                              dmem_rsp_valid,
    input  logic [DBITS-1:0]                  dmem_rsp_rdata
);

    agex_latch_t ag;
    mem_latch_t  mem_q, mem_d;
    mem_state_e  state, state_nxt;
    logic        drop_rsp;

    logic        is_mem, is_ld, mis_al;
    logic        mem_v, issue, accept, rsp_ok, complete, stall, fwd_valid;
    logic [DBITS-1:0] ld_data;

    assign ag = agex_latch_t'(from_AGEX_latch);

    mem_align u_align (
        .op       (ag.op_I),
        .addr_lo  (ag.result[1:0]),
        .st_data  (ag.st_data),
        .rdata    (dmem_rsp_rdata),
        .is_mem   (is_mem),
        .is_ld    (is_ld),
        .misalign (mis_al),
        .be       (dmem_req_be),
        .wdata    (dmem_req_wdata),
        .ld_data  (ld_data)
    );

    assign mem_v = ag.valid & is_mem;
    // Misaligned accesses never reach memory; they retire immediately.
    assign issue = mem_v & ~mis_al;

    // Request fields come straight from the input latch, which upstream holds
    // while we stall, so they stay stable until acceptance.
    assign dmem_req_we   = ~is_ld;
    assign dmem_req_addr = {ag.result[DBITS-1:2], 2'b00};

    always_comb begin
        state_nxt      = state;
        dmem_req_valid = 1'b0;
        rsp_ok         = 1'b0;
        case (state)
            MEM_IDLE, MEM_REQ: dmem_req_valid = issue;
            // Responses outside WAIT, or before any post-reset acceptance,
            // belong to an access that reset cut off.
            MEM_WAIT:          rsp_ok = dmem_rsp_valid & ~drop_rsp;
            default: ;
        endcase
        if (!reset)
            dmem_req_valid = 1'b0;
        accept   = dmem_req_valid & dmem_req_ready;
        complete = issue ? (is_ld ? rsp_ok : accept) : 1'b1;
        stall    = reset & mem_v & ~complete;

        case (state)
            MEM_IDLE: if (issue) state_nxt = accept ? (is_ld ? MEM_WAIT : MEM_IDLE) : MEM_REQ;
            MEM_REQ:  if (!issue)     state_nxt = MEM_IDLE;
                      else if (accept) state_nxt = is_ld ? MEM_WAIT : MEM_IDLE;
            MEM_WAIT: if (rsp_ok) state_nxt = MEM_IDLE;
            default:  state_nxt = MEM_IDLE;
        endcase
    end

    always_comb begin
        mem_d = '0;
        if (!stall) begin
            mem_d.valid      = ag.valid;
            mem_d.inst       = ag.inst;
            mem_d.PC         = ag.PC;
            mem_d.op_I       = ag.op_I;
            mem_d.inst_count = ag.inst_count;
            mem_d.wb_data    = (issue & is_ld) ? ld_data : ag.result;
            mem_d.rd         = ag.rd;
            // Stores and misaligned accesses never write the register file.
            mem_d.wr_reg     = ag.valid & ag.wr_reg & ~(mem_v & (~is_ld | mis_al));
            mem_d.misalign   = mem_v & mis_al;
            mem_d.bus_canary = ag.bus_canary;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= MEM_IDLE;
            mem_q    <= '0;
            drop_rsp <= 1'b1;
        end else begin
            state <= state_nxt;
            mem_q <= mem_d;
            if (accept)
                drop_rsp <= 1'b0;
        end
    end

    assign fwd_valid        = mem_q.valid & mem_q.wr_reg & (mem_q.rd != '0);
    assign MEM_latch_out    = mem_q;
    assign from_MEM_to_AGEX = stall;
    assign from_MEM_to_DE   = {stall, fwd_valid, mem_q.rd, mem_q.wb_data};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a scoreboard. Stimulus pushes the
// expected MEM latch contents; a monitor pops and compares on every valid
// MEM latch. Handshake timing is checked inline at each negedge.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    agex_latch_t ag;
    logic [AGEX_LATCH_WIDTH-1:0]       agex_v;
    logic [MEM_LATCH_WIDTH-1:0]        mem_v;
    logic [FROM_MEM_TO_AGEX_WIDTH-1:0] to_agex;
    logic [FROM_MEM_TO_DE_WIDTH-1:0]   to_de;
    logic              req_valid, req_ready, req_we, rsp_valid;
    logic [DBITS-1:0]  req_addr, req_wdata, rsp_rdata;
    logic [BE_BITS-1:0] req_be;
    mem_latch_t ml;

    assign agex_v = ag;
    assign ml     = mem_latch_t'(mem_v);

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .from_AGEX_latch  (agex_v),
        .MEM_latch_out    (mem_v),
        .from_MEM_to_AGEX (to_agex),
        .from_MEM_to_DE   (to_de),
        .dmem_req_valid   (req_valid),
        .dmem_req_ready   (req_ready),
        .dmem_req_we      (req_we),
        .dmem_req_addr    (req_addr),
        .dmem_req_wdata   (req_wdata),
        .dmem_req_be      (req_be),
        .dmem_rsp_valid   (rsp_valid),
        .dmem_rsp_rdata   (rsp_rdata)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        wr;
        logic        mis;
        logic        chk_wb;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && ml.valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL sb_unexpected: got pc %h expected no output", ml.PC);
            end else begin
                e = q.pop_front();
                chk("sb_pc", ml.PC, e.pc);
                if (e.chk_wb) chk("sb_wb_data", ml.wb_data, e.wb);
                chk("sb_rd", 32'(ml.rd), 32'(e.rd));
                chk("sb_wr_reg", 32'(ml.wr_reg), 32'(e.wr));
                chk("sb_misalign", 32'(ml.misalign), 32'(e.mis));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input op_t op, input logic [31:0] res, input logic [31:0] st,
                          input logic [4:0] rd, input logic wr, input logic [31:0] pc);
        ag            = '0;
        ag.valid      = 1'b1;
        ag.inst       = 32'h0000_0013 | pc;
        ag.PC         = pc;
        ag.op_I       = op;
        ag.inst_count = pc >> 2;
        ag.result     = res;
        ag.st_data    = st;
        ag.rd         = rd;
        ag.wr_reg     = wr;
        ag.bus_canary = 32'hCAFE_0000 | pc;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] wb, input logic [4:0] rd,
                        input logic wr, input logic mis, input logic cw);
        exp_t x;
        x.pc = pc; x.wb = wb; x.rd = rd; x.wr = wr; x.mis = mis; x.chk_wb = cw;
        q.push_back(x);
    endtask

    // Load accepted immediately, response one cycle later.
    task automatic do_load(input op_t op, input logic [31:0] addr, input logic [31:0] word,
                           input logic [31:0] exp, input logic [31:0] pc);
        set_op(op, addr, 32'h0, 5'd3, 1'b1, pc);
        push(pc, exp, 5'd3, 1'b1, 1'b0, 1'b1);
        req_ready = 1'b1;
        @(negedge clk);
        chk("ld_req_valid", 32'(req_valid), 1);
        chk("ld_stall_acc", 32'(to_agex), 1);
        step();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = word;
        @(negedge clk);
        chk("ld_stall_rsp", 32'(to_agex), 0);
        step();
        rsp_valid = 1'b0;
        ag = '0;
    endtask

    task automatic do_store(input op_t op, input logic [31:0] addr, input logic [31:0] st,
                            input logic [3:0] be, input logic [31:0] wd, input logic [31:0] pc);
        set_op(op, addr, st, 5'd4, 1'b1, pc);
        push(pc, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        req_ready = 1'b1;
        @(negedge clk);
        chk("st_be", 32'(req_be), 32'(be));
        chk("st_wdata", req_wdata, wd);
        chk("st_stall", 32'(to_agex), 0);
        step();
        req_ready = 1'b0;
        ag = '0;
    endtask

    initial begin
        reset = 1'b0;
        ag = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_latch_zero", 32'(|mem_v), 0);
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_stall", 32'(to_agex), 0);
        reset = 1'b1;
        step();

        // ADD pass-through
        set_op(OP_ADD, 32'h11, 32'h0, 5'd5, 1'b1, 32'h1000);
        push(32'h1000, 32'h11, 5'd5, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("add_req_valid", 32'(req_valid), 0);
        chk("add_stall", 32'(to_agex), 0);
        step();
        ag = '0;
        @(negedge clk);
        chk("add_fwd_valid", 32'(to_de[DBITS+REGNOBITS]), 1);
        chk("add_fwd_rd", 32'(to_de[DBITS+REGNOBITS-1:DBITS]), 5);
        chk("add_fwd_data", to_de[DBITS-1:0], 32'h11);
        step();

        // LW with 3-cycle response
        set_op(OP_LW, 32'h100, 32'h0, 5'd6, 1'b1, 32'h1004);
        push(32'h1004, 32'hDEAD_BEEF, 5'd6, 1'b1, 1'b0, 1'b1);
        req_ready = 1'b1;
        @(negedge clk);
        chk("lw_req_valid", 32'(req_valid), 1);
        chk("lw_addr", req_addr, 32'h100);
        chk("lw_we", 32'(req_we), 0);
        chk("lw_stall_c0", 32'(to_agex), 1);
        chk("lw_de_stall_c0", 32'(to_de[DBITS+REGNOBITS+1]), 1);
        step();
        req_ready = 1'b0;
        @(negedge clk);
        chk("lw_req_valid_c1", 32'(req_valid), 0);
        chk("lw_stall_c1", 32'(to_agex), 1);
        chk("lw_bubble_c1", 32'(ml.valid), 0);
        step();
        @(negedge clk);
        chk("lw_stall_c2", 32'(to_agex), 1);
        step();
        rsp_valid = 1'b1;
        rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lw_stall_c3", 32'(to_agex), 0);
        step();
        rsp_valid = 1'b0;
        ag = '0;

        // SB with ready held low for two cycles; input wr_reg=1 must be dropped
        set_op(OP_SB, 32'h203, 32'hA5, 5'd7, 1'b1, 32'h1008);
        push(32'h1008, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0);
        req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("sb_req_valid", 32'(req_valid), 1);
            chk("sb_addr", req_addr, 32'h200);
            chk("sb_we", 32'(req_we), 1);
            chk("sb_be", 32'(req_be), 32'h8);
            chk("sb_wdata", req_wdata, 32'hA5A5_A5A5);
            chk("sb_stall", 32'(to_agex), 1);
            step();
        end
        req_ready = 1'b1;
        @(negedge clk);
        chk("sb_req_valid_acc", 32'(req_valid), 1);
        chk("sb_stall_acc", 32'(to_agex), 0);
        step();
        req_ready = 1'b0;
        ag = '0;

        // Load extraction
        do_load(OP_LB,  32'h1, 32'h0000_8000, 32'hFFFF_FF80, 32'h100C);
        do_load(OP_LBU, 32'h1, 32'h0000_8000, 32'h0000_0080, 32'h1010);
        do_load(OP_LH,  32'h2, 32'h8001_0000, 32'hFFFF_8001, 32'h1014);
        do_load(OP_LHU, 32'h2, 32'h8001_0000, 32'h0000_8001, 32'h1018);

        // Store alignment
        do_store(OP_SH, 32'h2, 32'h0000_1234, 4'b1100, 32'h1234_1234, 32'h101C);
        do_store(OP_SW, 32'h4, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF, 32'h1020);

        // Misaligned halfword
        set_op(OP_LH, 32'h101, 32'h0, 5'd9, 1'b1, 32'h1024);
        push(32'h1024, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mis_req_valid", 32'(req_valid), 0);
        chk("mis_stall", 32'(to_agex), 0);
        step();
        ag = '0;

        // Reset while in WAIT_RSP, then a stale response
        set_op(OP_LW, 32'h300, 32'h0, 5'd10, 1'b1, 32'h1028);
        req_ready = 1'b1;
        @(negedge clk);
        chk("rw_req_valid", 32'(req_valid), 1);
        step();
        req_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rw_rst_req_valid", 32'(req_valid), 0);
        chk("rw_rst_stall", 32'(to_agex), 0);
        step();
        reset = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hBAD0_BAD0;
        set_op(OP_LW, 32'h400, 32'h0, 5'd11, 1'b1, 32'h102C);
        push(32'h102C, 32'h1234_5678, 5'd11, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("rw_latch_zero", 32'(|mem_v), 0);
        chk("rw_stale_stall", 32'(to_agex), 1);
        chk("rw_stale_req_valid", 32'(req_valid), 1);
        step();
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        chk("rw_acc_stall", 32'(to_agex), 1);
        step();
        req_ready = 1'b0;
        @(negedge clk);
        chk("rw_wait_req_valid", 32'(req_valid), 0);
        chk("rw_wait_stall", 32'(to_agex), 1);
        step();
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rw_rsp_stall", 32'(to_agex), 0);
        step();
        rsp_valid = 1'b0;
        ag = '0;
        step();
        step();
        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
